number_stream_src: RTL

//   Producer side of the next/number stream consumed by the mode finder.
//   A sequence of bytes is loaded into an internal buffer. On start, the buffer
//   is replayed as one number per clock with next=1, then a done pulse is raised.

---
 rtl/number_stream_src_pkg.sv | 10 +
 rtl/number_stream_src_buf.sv | 18 +
 rtl/number_stream_src.sv | 92 +++++++++
 3 files changed

// File: rtl/number_stream_src_pkg.sv
// number_stream_src_pkg: shared state encoding and default stream dimensions
package number_stream_src_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 32;
endpackage

// File: rtl/number_stream_src_buf.sv
// stream_buf: DEPTH x WIDTH register array, one write port, one combinational read port
module stream_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/number_stream_src.sv
// number_stream_src: loads a byte buffer, replays it as one next/number per clock, then pulses done
module number_stream_src
  import number_stream_src_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  input  logic             start,
  input  logic             hold,
  output logic             next,
  output logic [WIDTH-1:0] number,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             overflow
);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  state_t state, state_n;
  logic [CW-1:0] rd_ptr, rd_n, count_n;
  logic [WIDTH-1:0] number_n, rd_data;
  logic ovf_n, next_n, we;
  stream_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .we(we),
    .waddr(count[AW-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rd_data)
  );
  always_comb begin
    state_n = state;
    rd_n = rd_ptr;
    count_n = count;
    ovf_n = overflow;
    number_n = number;
    next_n = 1'b0;
    we = 1'b0;
    if (state == S_IDLE) begin
      if (clear) begin
        count_n = '0;
        ovf_n = 1'b0;
      end else if (wr_en) begin
        if (count == FULL_C) ovf_n = 1'b1;
        else begin
          we = 1'b1;
          count_n = count + 1'b1;
        end
      end else if (start) state_n = (count == '0) ? S_DONE : S_PLAY;
    end else if (state == S_PLAY) begin
      if (!hold) begin
        if (rd_ptr == count) begin
          state_n = S_DONE;
          rd_n = '0;
        end else begin
          next_n = 1'b1;
          number_n = rd_data;
          rd_n = rd_ptr + 1'b1;
        end
      end
    end else state_n = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      number <= '0;
      next <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      full <= 1'b0;
    end else begin
      state <= state_n;
      rd_ptr <= rd_n;
      count <= count_n;
      overflow <= ovf_n;
      number <= number_n;
      next <= next_n;
      busy <= state_n == S_PLAY;
      done <= state_n == S_DONE;
      full <= count_n == FULL_C;
    end
endmodule
